// File: rtl/clkmon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkmon_pkg
// Description : Shared types and helpers for the clock monitor.
//               state_t  - monitor FSM states
//               in_range - |value - expected| <= tol check
// Revision    : 1.0 - initial release
// ============================================================================
package clkmon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        MEASURE = 2'd2,
        LOST    = 2'd3
    } state_t;

    // Absolute-difference compare, written without signed arithmetic so
    // that it behaves the same for any unsigned counter width up to 32.
    function automatic logic in_range(input logic [31:0] value,
                                      input logic [31:0] expected,
                                      input logic [31:0] tol);
        logic [31:0] diff;
        diff = (value >= expected) ? (value - expected) : (expected - value);
        return (diff <= tol);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_monitor_if
// Description : Signal bundle between the clock monitor and its user.
//               sig_in/enable/clear flow into the monitor; period_out,
//               high_out, period_valid, locked, lost, err flow out.
//               master - user side, slave - monitor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_monitor_if #(
    parameter int CNT_W = 16
);
    logic             sig_in;
    logic             enable;
    logic             clear;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             period_valid;
    logic             locked;
    logic             lost;
    logic             err;

    modport master (
        output sig_in, enable, clear,
        input  period_out, high_out, period_valid, locked, lost, err
    );

    modport slave (
        input  sig_in, enable, clear,
        output period_out, high_out, period_valid, locked, lost, err
    );
endinterface
`default_nettype wire

// File: rtl/clkmon_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : clkmon_sync_edge
// Description : Multi-stage synchroniser for an asynchronous clock input,
//               followed by single-cycle rise/fall detectors.
//               clk_i   - sampling clock
//               rst_ni  - asynchronous active-low reset
//               sig_i   - asynchronous input
//               sync_o  - synchronised level
//               rise_o  - 1 for one cycle after sync_o goes 0->1
//               fall_o  - 1 for one cycle after sync_o goes 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module clkmon_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/clock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : clock_monitor
// Description : Measures the period of an asynchronous clock (sig_in) in
//               clk_in cycles and reports lock / loss-of-clock / range error.
//               clk_in   - system clock
//               reset_n  - asynchronous active-low reset
//               mon      - clock_monitor_if.slave (sig_in, enable, clear in;
//                          period_out, high_out, period_valid, locked, lost,
//                          err out)
//               Optional: define CLKMON_DUTY_EN to measure the high time of
//               sig_in into high_out; otherwise high_out is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_monitor
    import clkmon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int EXP_PERIOD  = 4,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            reset_n,
    clock_monitor_if.slave  mon
);

    localparam int               LOCK_W      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT);
    localparam logic [LOCK_W-1:0] c_lock_cnt = LOCK_W'(LOCK_CNT);

    logic w_sync, w_rise, w_fall;

    clkmon_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i  (clk_in),
        .rst_ni (reset_n),
        .sig_i  (mon.sig_in),
        .sync_o (w_sync),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [LOCK_W-1:0] lock_ctr_q, lock_ctr_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic              lost_q, lost_d;
    logic              err_q, err_d;
    logic              w_in_range;

    assign w_in_range = in_range(32'(cnt_q), 32'(EXP_PERIOD), 32'(TOL));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            lock_ctr_q <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            lock_ctr_q <= lock_ctr_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            lost_q     <= lost_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        lock_ctr_d = lock_ctr_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        lost_d     = lost_q;
        // Clear is applied first so that a range error in the same cycle
        // overrides it below.
        err_d      = mon.clear ? 1'b0 : err_q;

        if (w_rise)
            cnt_d = CNT_W'(1);
        else if (cnt_q != c_cnt_max)
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;

        if (!mon.enable) begin
            state_d    = IDLE;
            cnt_d      = '0;
            lock_ctr_d = '0;
            locked_d   = 1'b0;
            lost_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                end
                ACQUIRE: begin
                    // The first edge only starts the count; no period yet.
                    if (w_rise) begin
                        state_d = MEASURE;
                    end else if (cnt_q >= c_timeout) begin
                        state_d    = LOST;
                        lost_d     = 1'b1;
                        locked_d   = 1'b0;
                        lock_ctr_d = '0;
                    end
                end
                MEASURE: begin
                    // Rise is tested before timeout: an edge arriving on the
                    // timeout cycle is a (long) period, not a loss.
                    if (w_rise) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        if (w_in_range) begin
                            if (lock_ctr_q != c_lock_cnt)
                                lock_ctr_d = lock_ctr_q + LOCK_W'(1);
                            if (lock_ctr_d == c_lock_cnt)
                                locked_d = 1'b1;
                        end else begin
                            lock_ctr_d = '0;
                            locked_d   = 1'b0;
                            err_d      = 1'b1;
                        end
                    end else if (cnt_q >= c_timeout) begin
                        state_d    = LOST;
                        lost_d     = 1'b1;
                        locked_d   = 1'b0;
                        lock_ctr_d = '0;
                    end
                end
                LOST: begin
                    // Recovery edge restarts the count but reports nothing,
                    // since the gap before it is not a real period.
                    if (w_rise) begin
                        state_d = MEASURE;
                        lost_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign mon.period_out   = period_q;
    assign mon.period_valid = valid_q;
    assign mon.locked       = locked_q;
    assign mon.lost         = lost_q;
    assign mon.err          = err_q;

`ifdef CLKMON_DUTY_EN
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] high_q, high_d;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            high_cnt_q <= '0;
            high_q     <= '0;
        end else begin
            high_cnt_q <= high_cnt_d;
            high_q     <= high_d;
        end
    end

    // The rise cycle already has sync high, so it seeds the count with 1.
    always_comb begin
        high_d = high_q;
        if (w_rise)
            high_cnt_d = CNT_W'(1);
        else if (w_sync && (high_cnt_q != c_cnt_max))
            high_cnt_d = high_cnt_q + CNT_W'(1);
        else
            high_cnt_d = high_cnt_q;

        // Only a fall that follows a tracked rise yields a meaningful width.
        if (w_fall && mon.enable && (state_q == MEASURE))
            high_d = high_cnt_q;
    end

    assign mon.high_out = high_q;
`else
    logic w_unused_duty;
    assign w_unused_duty = w_sync ^ w_fall;
    assign mon.high_out  = '0;
`endif

endmodule
`default_nettype wire
